// File: rtl/shift_panel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_panel: button debounce, operand capture, ARM barrel shift and       |
// | result history ring. Option macro: SHIFT_PANEL_HIST_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shift_panel #(
    parameter int WIDTH      = 32,
    parameter int DEB_CYCLES = 500000,
    parameter int HIST_DEPTH = 8,
    localparam int SW        = $clog2(WIDTH),
    localparam int HW        = $clog2(HIST_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [5:0]       btn,
    output logic [WIDTH-1:0] disp_data,
    output logic             carry_out,
    output logic             carry_flag,
    output logic [HW-1:0]    view_idx,
    output logic [HW:0]      hist_count,
    output logic [WIDTH-1:0] led
);

    localparam int         CW  = $clog2(DEB_CYCLES);
    localparam logic [8:0] c_W = 9'(WIDTH);

    logic [5:0]       w_pulse;
    logic [10:0]      w_sw_lo;
    logic [WIDTH-1:0] r_data;
    logic [7:0]       r_num;
    logic [2:0]       r_op;
    logic             r_carry_flag;

    // Accepted level flips only after DEB_CYCLES consecutive differing samples.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_deb
            logic [1:0]    r_sync;
            logic          r_level;
            logic          r_pulse;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync  <= '0;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync  <= {r_sync[0], btn[gi]};
                    r_pulse <= 1'b0;
                    if (r_sync[1] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_level <= r_sync[1];
                        r_pulse <= r_sync[1];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_pulse[gi] = r_pulse;
        end

        if (WIDTH >= 11) begin : g_sw_wide
            assign w_sw_lo = sw[10:0];
        end else begin : g_sw_narrow
            assign w_sw_lo = {{(11 - WIDTH){1'b0}}, sw};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_num        <= '0;
            r_op         <= '0;
            r_carry_flag <= 1'b0;
        end else begin
            if (w_pulse[0]) r_data <= sw;
            if (w_pulse[1]) begin
                r_num <= w_sw_lo[10:3];
                r_op  <= w_sw_lo[2:0];
            end
            if (w_pulse[3]) r_carry_flag <= ~r_carry_flag;
        end
    end

    logic [8:0]       w_n;
    logic [8:0]       w_amt;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_tap;
    logic             w_c;

    // Carry taps are taken as bit 0 of a right shift so n = WIDTH needs no special index.
    always_comb begin
        w_res = r_data;
        w_c   = r_carry_flag;
        w_tap = '0;
        w_amt = 9'd0;
        w_n   = r_op[0] ? {1'b0, r_num} : {1'b0, r_num & 8'(WIDTH - 1)};
        if (w_n != 9'd0 || !r_op[0]) begin
            case (r_op[2:1])
                2'b00: begin
                    if (w_n != 9'd0) begin
                        if (w_n <= c_W) begin
                            w_res = r_data << w_n;
                            w_tap = r_data >> (c_W - w_n);
                            w_c   = w_tap[0];
                        end else begin
                            w_res = '0;
                            w_c   = 1'b0;
                        end
                    end
                end
                2'b01: begin
                    w_amt = (w_n == 9'd0) ? c_W : w_n;
                    if (w_amt <= c_W) begin
                        w_res = r_data >> w_amt;
                        w_tap = r_data >> (w_amt - 9'd1);
                        w_c   = w_tap[0];
                    end else begin
                        w_res = '0;
                        w_c   = 1'b0;
                    end
                end
                2'b10: begin
                    w_amt = (w_n == 9'd0 || w_n > c_W) ? c_W : w_n;
                    w_res = $signed(r_data) >>> w_amt;
                    w_tap = r_data >> (w_amt - 9'd1);
                    w_c   = w_tap[0];
                end
                default: begin
                    if (w_n == 9'd0) begin
                        w_res = {r_carry_flag, r_data[WIDTH-1:1]};
                        w_c   = r_data[0];
                    end else begin
                        w_amt = w_n & (c_W - 9'd1);
                        w_res = (r_data >> w_amt) | (r_data << (c_W - w_amt));
                        w_c   = w_res[WIDTH-1];
                    end
                end
            endcase
        end
    end

`ifdef SHIFT_PANEL_HIST_EN
    logic [WIDTH-1:0]      r_hist_res [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] r_hist_c;
    logic [HW-1:0]         r_wr_ptr;
    logic [HW-1:0]         r_view;
    logic [HW-1:0]         w_rd_ptr;
    logic [HW:0]           r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_view   <= '0;
            r_count  <= '0;
        end else if (w_pulse[2]) begin
            r_hist_res[r_wr_ptr] <= w_res;
            r_hist_c[r_wr_ptr]   <= w_c;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
            r_view               <= '0;
            if (r_count != (HW + 1)'(HIST_DEPTH)) r_count <= r_count + 1'b1;
        end else if (w_pulse[4] && !w_pulse[5]) begin
            if ({1'b0, r_view} + 1'b1 < r_count) r_view <= r_view + 1'b1;
        end else if (w_pulse[5] && !w_pulse[4]) begin
            if (r_view != '0) r_view <= r_view - 1'b1;
        end
    end

    // Age 0 sits just behind the write pointer.
    assign w_rd_ptr   = r_wr_ptr - 1'b1 - r_view;
    assign disp_data  = (r_count == '0) ? '0 : r_hist_res[w_rd_ptr];
    assign carry_out  = (r_count == '0) ? 1'b0 : r_hist_c[w_rd_ptr];
    assign view_idx   = r_view;
    assign hist_count = r_count;
`else
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_valid;
    logic             w_unused;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_pulse[2]) begin
            r_res   <= w_res;
            r_cout  <= w_c;
            r_valid <= 1'b1;
        end
    end

    assign w_unused   = ^w_pulse[5:4];
    assign disp_data  = r_res;
    assign carry_out  = r_cout;
    assign view_idx   = '0;
    assign hist_count = {{HW{1'b0}}, r_valid};
`endif

    assign carry_flag = r_carry_flag;
    assign led        = {carry_out, {(WIDTH - 2){1'b0}}, r_carry_flag};

endmodule
`default_nettype wire

// File: tb/tb_shift_panel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shift_panel: vector table, directed corner sequences and random       |
// | button traffic against a queue-based reference model.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_shift_panel;
    localparam int WIDTH = 32;
    localparam int DEB   = 4;
    localparam int HD    = 4;
    localparam int HW    = 2;
`ifdef SHIFT_PANEL_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif
    localparam int CAP = HIST ? HD : 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      sw    = '0;
    logic [5:0]       btn   = '0;
    logic [31:0]      disp_data;
    logic             carry_out;
    logic             carry_flag;
    logic [HW-1:0]    view_idx;
    logic [HW:0]      hist_count;
    logic [31:0]      led;

    shift_panel #(.WIDTH(WIDTH), .DEB_CYCLES(DEB), .HIST_DEPTH(HD)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
        .disp_data(disp_data), .carry_out(carry_out), .carry_flag(carry_flag),
        .view_idx(view_idx), .hist_count(hist_count), .led(led)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] m_data;
    logic [7:0]  m_num;
    logic [2:0]  m_op;
    logic        m_c;
    logic [32:0] m_hist[$];
    int          m_view;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  num;
        logic [2:0]  op;
        logic        cin;
        logic [31:0] exp_res;
        logic        exp_c;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ARM shift rules evaluated bit-by-bit; returns {carry, result}.
    function automatic logic [32:0] ref_shift(input logic [31:0] d, input logic [7:0] num,
                                              input logic [2:0] op, input logic c);
        int n;
        logic [31:0] r;
        logic co;
        n  = op[0] ? int'(num) : int'(num) % 32;
        r  = d;
        co = c;
        if (n == 0 && op[0]) return {c, d};
        case (op[2:1])
            2'd0: begin
                if (n > 0 && n < 32) begin r = d << n; co = d[32-n]; end
                else if (n == 32) begin r = 0; co = d[0]; end
                else if (n > 32) begin r = 0; co = 0; end
            end
            2'd1: begin
                if (n == 0) n = 32;
                if (n < 32) begin r = d >> n; co = d[n-1]; end
                else if (n == 32) begin r = 0; co = d[31]; end
                else begin r = 0; co = 0; end
            end
            2'd2: begin
                if (n == 0) n = 32;
                if (n < 32) begin
                    repeat (n) r = {r[31], r[31:1]};
                    co = d[n-1];
                end else begin
                    r = {32{d[31]}}; co = d[31];
                end
            end
            default: begin
                if (n == 0) begin r = {c, d[31:1]}; co = d[0]; end
                else begin
                    repeat (n % 32) r = {r[0], r[31:1]};
                    co = r[31];
                end
            end
        endcase
        return {co, r};
    endfunction

    task automatic model_reset();
        m_data = '0; m_num = '0; m_op = '0; m_c = 1'b0;
        m_hist.delete();
        m_view = 0;
    endtask

    // Hold long enough for one accepted press, then release and let it settle.
    task automatic press(input logic [5:0] mask);
        logic [32:0] r;
        btn = mask;
        repeat (10) @(posedge clk);
        btn = '0;
        repeat (10) @(posedge clk);
        if (mask[2]) begin
            r = ref_shift(m_data, m_num, m_op, m_c);
            m_hist.push_back(r);
            if (m_hist.size() > CAP) void'(m_hist.pop_front());
            m_view = 0;
        end else if (HIST && mask[4] && !mask[5]) begin
            if (m_view < m_hist.size() - 1) m_view++;
        end else if (HIST && mask[5] && !mask[4]) begin
            if (m_view > 0) m_view--;
        end
        if (mask[0]) m_data = sw;
        if (mask[1]) begin m_num = sw[10:3]; m_op = sw[2:0]; end
        if (mask[3]) m_c = ~m_c;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_disp;
        logic        e_co;
        int          sz;
        sz = m_hist.size();
        e_disp = '0;
        e_co   = 1'b0;
        if (sz > 0) begin
            e_disp = m_hist[sz-1-m_view][31:0];
            e_co   = m_hist[sz-1-m_view][32];
        end
        @(negedge clk);
        chk({tag, ".disp"},  64'(disp_data),  64'(e_disp));
        chk({tag, ".cout"},  64'(carry_out),  64'(e_co));
        chk({tag, ".cflag"}, 64'(carry_flag), 64'(m_c));
        chk({tag, ".view"},  64'(view_idx),   64'(m_view));
        chk({tag, ".count"}, 64'(hist_count), 64'(sz));
        chk({tag, ".led"},   64'(led),        64'({e_co, 30'b0, m_c}));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h80000001, 8'd1,  3'b000, 1'b0, 32'h00000002, 1'b1};
        vecs[1]  = '{32'h80000001, 8'd0,  3'b110, 1'b1, 32'hC0000000, 1'b1};
        vecs[2]  = '{32'h80000000, 8'd40, 3'b101, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[3]  = '{32'h80000000, 8'd40, 3'b011, 1'b1, 32'h00000000, 1'b0};
        vecs[4]  = '{32'h80000000, 8'd0,  3'b010, 1'b0, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h00000001, 8'd32, 3'b001, 1'b0, 32'h00000000, 1'b1};
        vecs[6]  = '{32'h12345678, 8'd32, 3'b111, 1'b0, 32'h12345678, 1'b0};
        vecs[7]  = '{32'h0000000F, 8'd4,  3'b111, 1'b1, 32'hF0000000, 1'b1};
        vecs[8]  = '{32'h00000005, 8'd0,  3'b001, 1'b1, 32'h00000005, 1'b1};
        vecs[9]  = '{32'h80000010, 8'd4,  3'b100, 1'b0, 32'hF8000001, 1'b0};
        vecs[10] = '{32'hC0000000, 8'd31, 3'b010, 1'b0, 32'h00000001, 1'b1};
        vecs[11] = '{32'h00000003, 8'd33, 3'b000, 1'b0, 32'h00000006, 1'b0};

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        check_model("reset");
        rst_n = 1'b1;

        // Too-short press must not execute.
        @(negedge clk);
        btn = 6'b000100;
        repeat (3) @(posedge clk);
        btn = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("glitch.count", 64'(hist_count), 64'd0);

        for (int i = 0; i < 12; i++) begin
            sw = vecs[i].data;
            press(6'b000001);
            sw = {21'b0, vecs[i].num, vecs[i].op};
            press(6'b000010);
            if (m_c != vecs[i].cin) press(6'b001000);
            press(6'b000100);
            @(negedge clk);
            chk($sformatf("vec%0d.res", i),  64'(disp_data), 64'(vecs[i].exp_res));
            chk($sformatf("vec%0d.cout", i), 64'(carry_out), 64'(vecs[i].exp_c));
            chk($sformatf("vec%0d.led", i),  64'(led), 64'({vecs[i].exp_c, 30'b0, vecs[i].cin}));
            check_model($sformatf("vec%0d", i));
        end

        // Five LSL executes fill and wrap the ring, then scroll to the oldest.
        sw = 32'd1;
        press(6'b000001);
        for (int n = 1; n <= 5; n++) begin
            sw = 32'(n) << 3;
            press(6'b000010);
            press(6'b000100);
        end
        @(negedge clk);
        chk("fill.count", 64'(hist_count), HIST ? 64'd4 : 64'd1);
        chk("fill.newest", 64'(disp_data), 64'h20);
        for (int k = 0; k < 4; k++) press(6'b010000);
        @(negedge clk);
        chk("scroll.view", 64'(view_idx), HIST ? 64'd3 : 64'd0);
        chk("scroll.disp", 64'(disp_data), HIST ? 64'h04 : 64'h20);
        check_model("scroll");
        press(6'b000100);
        @(negedge clk);
        chk("exec.view", 64'(view_idx), 64'd0);
        check_model("exec_after_scroll");

        // Simultaneous load and execute: execute sees pre-load registers.
        sw = 32'hA5A5_00F3;
        press(6'b001111);
        check_model("simul");
        press(6'b110000);
        check_model("older_newer");

        for (int it = 0; it < 60; it++) begin
            sw = $urandom;
            if ($urandom_range(0, 1) == 1) sw[10:3] = 8'($urandom_range(0, 40));
            press(6'($urandom));
            check_model($sformatf("rand%0d", it));
        end

        // Reset in the middle of a scroll.
        press(6'b000100);
        press(6'b000100);
        press(6'b000100);
        if (!m_c) press(6'b001000);
        press(6'b010000);
        press(6'b010000);
        check_model("prereset");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.disp",  64'(disp_data),  64'd0);
        chk("rst.cout",  64'(carry_out),  64'd0);
        chk("rst.led",   64'(led),        64'd0);
        chk("rst.count", 64'(hist_count), 64'd0);
        chk("rst.view",  64'(view_idx),   64'd0);
        chk("rst.cflag", 64'(carry_flag), 64'd0);
        model_reset();

        // Toggle button held across reset release gives exactly one toggle.
        btn = 6'b001000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        btn = '0;
        repeat (12) @(posedge clk);
        m_c = 1'b1;
        check_model("held_reset");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/shift_panel.md
# shift_panel

Parametrised, fully synchronous front-panel controller for the ARM shifter bench. It debounces the push-buttons and captures operands from the switches. On request it evaluates an ARM barrel-shift on a generic data width and logs each result into a scrollable history ring. It sits between the board switches/buttons and the seven-segment Display driver (fed from `disp_data`) and LEDs.

## Interface
- `WIDTH`, 32: data width; power of two, 8..64; `SW = log2(WIDTH)`.
- `DEB_CYCLES`, 500000: consecutive stable samples required before a button level is accepted; ≥2.
- `HIST_DEPTH`, 8: history entries; power of two, 2..16; `HW = log2(HIST_DEPTH)`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sw` in WIDTH: switch bank, raw.
- `btn` in 6: raw buttons: [0] load data, [1] load num/op, [2] execute, [3] toggle carry, [4] history older, [5] history newer.
- `disp_data` out WIDTH: result of the viewed history entry.
- `carry_out` out 1: shifter carry of the viewed entry.
- `carry_flag` out 1: current C input.
- `view_idx` out HW: age of the viewed entry (0 = newest).
- `hist_count` out HW+1: valid entries, 0..HIST_DEPTH.
- `led` out WIDTH: {carry_out, zeros, carry_flag}; MSB is carry_out, LSB is carry_flag.

## Operation
- Per button: 2-flop synchroniser, then a counter. The accepted level changes only after DEB_CYCLES consecutive samples differ from it. An accepted 0→1 transition produces a one-cycle pulse. Release makes no pulse.
- Load data pulse: `data_r <= sw`.
- Load num/op pulse: `num_r <= sw[10:3]` (8 bits), `op_r <= sw[2:0]`.
- Toggle pulse: `carry_flag <= ~carry_flag`.
- `op_r[2:1]` selects the shift: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `op_r[0]` selects the form: 0 immediate (n = `num_r[SW-1:0]`), 1 register (n = `num_r` full 8 bits).
- Immediate n = 0:
  - LSL → data, C unchanged.
  - LSR → treated as n = WIDTH.
  - ASR → treated as n = WIDTH.
  - ROR → RRX: `{C, data[W-1:1]}`, carry = data[0].
- Register n = 0: data unchanged, carry = C, for all shift types.
- LSL, 0 < n < W: carry = data[W-n].
- LSL, n = W: result 0, carry = data[0].
- LSL, n > W: result 0, carry 0.
- LSR, 0 < n < W: carry = data[n-1].
- LSR, n = W: result 0, carry = data[W-1].
- LSR, n > W: result 0, carry 0.
- ASR, n ≥ W: all bits = data[W-1], carry = data[W-1].
- ROR register form: amount m = n mod W. If m = 0 and n ≠ 0: result = data, carry = data[W-1]. Otherwise rotate by m, carry = result[W-1].
- Execute pulse: computed result and carry are written to the ring at `wr_ptr`.
  - `wr_ptr` increments, wrapping at HIST_DEPTH.
  - `hist_count` saturates at HIST_DEPTH; when the ring is full the oldest entry is overwritten.
  - `view_idx` resets to 0.
- Older pulse: `view_idx++` only if `view_idx < hist_count-1`, else no change.
- Newer pulse: `view_idx--` only if `view_idx > 0`, else no change.
- Displayed entry = `(wr_ptr-1-view_idx) mod HIST_DEPTH`. If `hist_count` = 0, `disp_data` = 0 and `carry_out` = 0.
- Simultaneous pulses in one cycle, priority order:
  - Load data, load num/op and toggle act independently and in parallel.
  - Execute uses register values from before that cycle's loads.
  - Execute overrides older/newer.
  - Older and newer together: no view change.

## Timing
- Button press to pulse: 2 sync cycles + DEB_CYCLES.
- Execute pulse at cycle t: ring write and `hist_count`/`view_idx` update visible at t+1; `disp_data`/`carry_out` registered, valid at t+1.
- Load pulse at t: register updated at t+1; no effect on `disp_data` until the next execute.
- Reset (any cycle, including mid-debounce or mid-scroll) clears everything in one cycle:
  - `data_r`, `num_r`, `op_r` = 0; `carry_flag` = 0.
  - Debounced levels = 0; counters = 0.
  - `wr_ptr` = 0; `hist_count` = 0; `view_idx` = 0.
  - `disp_data` = 0; `carry_out` = 0; `led` = 0.
- A button held through reset release produces one pulse after DEB_CYCLES.

## Configuration
- `SHIFT_PANEL_HIST_EN` defined: history ring as above.
- Not defined:
  - Ring replaced by a single result register; HIST_DEPTH is ignored.
  - Older/newer buttons are ignored.
  - `view_idx` is tied to 0.
  - `hist_count` is 0 after reset and 1 after the first execute.

## Test plan
(WIDTH=32, DEB_CYCLES=4, HIST_DEPTH=4)
- Glitch: btn[2] high 3 cycles then low → no execute; `hist_count` stays 0.
- data=0x80000001, num=1, op=000 (LSL#1), execute → `disp_data`=0x00000002, `carry_out`=1, `led`=0x80000000.
- data=0x80000001, op=110, num=0, toggle carry to 1, execute → RRX: `disp_data`=0xC0000000, `carry_out`=1, `led`=0x80000001.
- data=0x80000000, op=101 (ASR reg), num=40, execute → 0xFFFFFFFF, carry 1; same with op=011 (LSR reg) → 0x00000000, carry 0.
- Five executes with LSL imm n=1..5 on data 1 → `hist_count`=4, newest 0x20. Four older presses → `view_idx` stops at 3, showing 0x04. Execute → `view_idx`=0.
- Reset asserted during a scroll (`view_idx`=2) → next cycle all outputs 0, `hist_count`=0.
